// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full adder: the cell the arr_mul ripple rows are built from.
//   A half adder is this cell with cin tied to 0.
// Ports
//   a, b  input   1  addend bits
//   cin   input   1  carry in
//   sum   output  1  a ^ b ^ cin
//   cout  output  1  majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/arr_mul.sv
// -----------------------------------------------------------------------------
// arr_mul
//   Unsigned WIDTH x WIDTH array multiplier with a registered 2*WIDTH product.
//   An AND array forms the partial products and rows of full_adder cells
//   ripple-sum them; the exact product is captured on every rising clk edge
//   (fixed 1-cycle latency, 1 product per cycle, no enable).
// Parameters
//   WIDTH  operand width in bits (>= 2); product width is 2*WIDTH
// Ports
//   clk  input   1        rising-edge clock
//   rst  input   1        asynchronous active-high reset, clears s
//   a    input   WIDTH    multiplicand, unsigned
//   b    input   WIDTH    multiplier, unsigned
//   s    output  2*WIDTH  registered product a*b
// -----------------------------------------------------------------------------
module arr_mul #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   s
);

   // pp[i][j] = a[j] & b[i]
   logic [WIDTH-1:0] pp [WIDTH];

   // acc[i] holds the WIDTH bits still to be summed after row i: the row's
   // upper sum bits with its carry-out on top. acc[0] is row 0 shifted down.
   logic [WIDTH-1:0] acc [WIDTH];

   logic [2*WIDTH-1:0] prod;

   for (genvar i = 0; i < WIDTH; i++) begin : g_and
      assign pp[i] = a & {WIDTH{b[i]}};
   end

   assign prod[0] = pp[0][0];
   assign acc[0]  = {1'b0, pp[0][WIDTH-1:1]};

   for (genvar i = 1; i < WIDTH; i++) begin : g_row
      logic [WIDTH:0]   carry;
      logic [WIDTH-1:0] row_sum;

      // First cell of each row has cin tied low, i.e. acts as a half adder.
      assign carry[0] = 1'b0;

      for (genvar j = 0; j < WIDTH; j++) begin : g_cell
         full_adder u_fa (
            .a    (pp[i][j]),
            .b    (acc[i-1][j]),
            .cin  (carry[j]),
            .sum  (row_sum[j]),
            .cout (carry[j+1])
         );
      end

      assign prod[i] = row_sum[0];
      assign acc[i]  = {carry[WIDTH], row_sum[WIDTH-1:1]};
   end

   // Last row's shifted sum and carry-out are the upper product bits.
   assign prod[2*WIDTH-1:WIDTH] = acc[WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s <= '0;
      end else begin
         s <= prod;
      end
   end

endmodule

// File: tb/tb_arr_mul.sv
module tb_arr_mul;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic [7:0] s;

   int checks;
   int errors;

   arr_mul #(
      .WIDTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .s   (s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something blocks.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      a   = 4'd5;
      b   = 4'd7;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (s !== 8'd0) begin
         errors++;
         $display("FAIL reset_async: s=%0d required=0", s);
      end
      a = 4'hF;
      b = 4'hF;
      step();
      step();
      checks++;
      if (s !== 8'd0) begin
         errors++;
         $display("FAIL reset_held: s=%0d required=0", s);
      end
      a   = 4'd0;
      b   = 4'd0;
      rst = 1'b0;
      step();
      checks++;
      if (s !== 8'd0) begin
         errors++;
         $display("FAIL reset_release_zero: s=%0d required=0", s);
      end
   endtask

   task automatic test_directed();
      logic [3:0] va [4];
      logic [3:0] vb [4];
      logic [7:0] ve [4];
      va[0] = 4'b0010; vb[0] = 4'b0011; ve[0] = 8'b0000_0110;
      va[1] = 4'b1010; vb[1] = 4'b0101; ve[1] = 8'b0011_0010;
      va[2] = 4'hF;    vb[2] = 4'hF;    ve[2] = 8'b1110_0001;
      va[3] = 4'b1001; vb[3] = 4'b0111; ve[3] = 8'b0011_1111;
      for (int k = 0; k < 4; k++) begin
         a = va[k];
         b = vb[k];
         step();
         checks++;
         if (s !== ve[k]) begin
            errors++;
            $display("FAIL directed_%0d: a=%0d b=%0d s=%0d required=%0d", k, va[k], vb[k], s, ve[k]);
         end
      end
      // Zero in either operand.
      a = 4'hF; b = 4'h0;
      step();
      checks++;
      if (s !== 8'd0) begin
         errors++;
         $display("FAIL zero_b: s=%0d required=0", s);
      end
      a = 4'h0; b = 4'hB;
      step();
      checks++;
      if (s !== 8'd0) begin
         errors++;
         $display("FAIL zero_a: s=%0d required=0", s);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] va [5];
      logic [3:0] vb [5];
      logic [7:0] ve [5];
      va[0] = 4'd3;  vb[0] = 4'd4;  ve[0] = 8'd12;
      va[1] = 4'd15; vb[1] = 4'd1;  ve[1] = 8'd15;
      va[2] = 4'd8;  vb[2] = 4'd8;  ve[2] = 8'd64;
      va[3] = 4'd13; vb[3] = 4'd11; ve[3] = 8'd143;
      va[4] = 4'd7;  vb[4] = 4'd14; ve[4] = 8'd98;
      a = va[0];
      b = vb[0];
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         // Before the edge-sampled value is checked, next inputs are already
         // applied; s must still hold the product sampled at the last edge.
         if (k < 4) begin
            a = va[k+1];
            b = vb[k+1];
         end
         #1;
         checks++;
         if (s !== ve[k]) begin
            errors++;
            $display("FAIL back_to_back_%0d: s=%0d required=%0d", k, s, ve[k]);
         end
      end
   endtask

   task automatic test_between_edges();
      // Glitchy inputs between edges: only the value present at the edge counts.
      a = 4'd9; b = 4'd9;
      #2 a = 4'd12; b = 4'd10;
      #2 a = 4'd6;  b = 4'd5;
      step();
      checks++;
      if (s !== 8'd30) begin
         errors++;
         $display("FAIL between_edges: s=%0d required=30", s);
      end
   endtask

   task automatic test_exhaustive();
      int bad;
      logic [7:0] exp_p;
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            a = 4'(i);
            b = 4'(j);
            step();
            exp_p = 8'(i * j);
            checks++;
            if (s !== exp_p) begin
               errors++;
               bad++;
               if (bad <= 8)
                  $display("FAIL exhaustive: a=%0d b=%0d s=%0d required=%0d", i, j, s, exp_p);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      a = 4'b1001; b = 4'b0111;
      step();
      checks++;
      if (s !== 8'd63) begin
         errors++;
         $display("FAIL mid_reset_pre: s=%0d required=63", s);
      end
      // Pending product 3*5=15 must never appear.
      a = 4'd3; b = 4'd5;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (s !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset_async: s=%0d required=0", s);
      end
      step();
      checks++;
      if (s !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset_held: s=%0d required=0", s);
      end
      a   = 4'd2;
      b   = 4'd2;
      #2 rst = 1'b0;
      step();
      checks++;
      if (s !== 8'd4) begin
         errors++;
         $display("FAIL mid_reset_release: s=%0d required=4", s);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_between_edges();
      test_exhaustive();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
